// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: merges stall/flush sources into per-stage
// enables/squashes, sequences HALT drain, and counts lost fetch cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hazard_stall      RAW hazard in D
//   branch_flush      taken branch resolved in X
//   imem_stall        imem not ready
//   dmem_stall        dmem busy (freezes pipeline)
//   halt_req          HALT in D
//   pc_en, fd_en, dx_en, xm_en, mwb_en   register enables
//   fd_flush, dx_bubble                   NOP injection into FD / DX
//   halted            registered halted flag
//   stall_cycles      registered saturating count of pc_en=0 cycles
module pipe_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_flush,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_en,
  output logic             mwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam logic [2:0] DRN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t     state;
  state_t     st;
  state_t     nxt_state;
  logic [2:0] drn;
  logic [2:0] nxt_drn;
  logic       flush_pend;
  logic       nxt_pend;
  logic       flush_eff;
  logic       go_halt;

  // While rst is high the outputs decode as RUN with no pending flush.
  always_comb begin
    st        = rst ? RUN : state;
    flush_eff = branch_flush | (flush_pend & ~rst);
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b0;
    dx_en     = 1'b0;
    dx_bubble = 1'b0;
    xm_en     = 1'b0;
    mwb_en    = 1'b0;
    nxt_state = st;
    nxt_drn   = drn;
    nxt_pend  = flush_pend;
    go_halt   = 1'b0;
    if (st == HALTED) begin
      nxt_state = HALTED;
    end else if (dmem_stall) begin
      // Remember a flush seen while frozen.
      nxt_pend = flush_pend | branch_flush;
    end else if (flush_eff) begin
      // Also squashes a draining HALT, which is younger than the branch.
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      fd_flush  = 1'b1;
      dx_en     = 1'b1;
      dx_bubble = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
      nxt_pend  = 1'b0;
      nxt_state = RUN;
    end else if (st == DRAIN) begin
      fd_en     = 1'b1;
      fd_flush  = 1'b1;
      dx_en     = 1'b1;
      dx_bubble = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
      if (drn == 3'd0) begin
        nxt_state = HALTED;
        go_halt   = 1'b1;
      end else begin
        nxt_drn = drn - 3'd1;
      end
    end else if (hazard_stall) begin
      dx_en     = 1'b1;
      dx_bubble = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
    end else if (halt_req) begin
      fd_en     = 1'b1;
      fd_flush  = 1'b1;
      dx_en     = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
      nxt_state = DRAIN;
      nxt_drn   = DRN_INIT;
    end else if (imem_stall) begin
      fd_en     = 1'b1;
      fd_flush  = 1'b1;
      dx_en     = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
    end else begin
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      dx_en     = 1'b1;
      xm_en     = 1'b1;
      mwb_en    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drn          <= 3'd0;
      flush_pend   <= 1'b0;
      halted       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= nxt_state;
      drn        <= nxt_drn;
      flush_pend <= nxt_pend;
      if (go_halt) begin
        halted <= 1'b1;
      end
      if (state != HALTED && !pc_en &&
          stall_cycles != {CNT_W{1'b1}}) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed plan plus random stimulus
// against a behavioural model of the sequencing rules.
module tb_pipe_stall_ctrl;

  localparam int CW = 4;
  localparam int DC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hazard_stall = 1'b0;
  logic          branch_flush = 1'b0;
  logic          imem_stall = 1'b0;
  logic          dmem_stall = 1'b0;
  logic          halt_req = 1'b0;
  logic          pc_en, fd_en, fd_flush, dx_en, dx_bubble;
  logic          xm_en, mwb_en, halted;
  logic [CW-1:0] stall_cycles;

  pipe_stall_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_stall),
    .branch_flush (branch_flush),
    .imem_stall   (imem_stall),
    .dmem_stall   (dmem_stall),
    .halt_req     (halt_req),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .fd_flush     (fd_flush),
    .dx_en        (dx_en),
    .dx_bubble    (dx_bubble),
    .xm_en        (xm_en),
    .mwb_en       (mwb_en),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctl;
    logic       hlt;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Model: mode 0 running, 1 draining, 2 halted.
  int m_mode = 0;
  int m_left = 0;
  int m_pend = 0;
  int m_cnt  = 0;
  int m_hlt  = 0;

  task automatic cyc(input bit r, input bit hz, input bit br,
                     input bit im, input bit dm, input bit hl);
    exp_t       e;
    int         mode;
    bit         fe;
    logic [6:0] c;
    @(posedge clk);
    #1;
    rst = r; hazard_stall = hz; branch_flush = br;
    imem_stall = im; dmem_stall = dm; halt_req = hl;
    mode = r ? 0 : m_mode;
    fe   = br || (!r && m_pend != 0);
    // bits: pc fd fdf dx dxb xm mwb
    if (mode == 2)      c = 7'b000_0000;
    else if (dm)        c = 7'b000_0000;
    else if (fe)        c = 7'b111_1111;
    else if (mode == 1) c = 7'b011_1111;
    else if (hz)        c = 7'b000_1111;
    else if (hl)        c = 7'b011_1011;
    else if (im)        c = 7'b011_1011;
    else                c = 7'b110_1011;
    e.ctl = c;
    e.hlt = (m_hlt != 0);
    e.cnt = m_cnt;
    q.push_back(e);
    if (r) begin
      m_mode = 0; m_left = 0; m_pend = 0; m_cnt = 0; m_hlt = 0;
    end else begin
      if (m_mode != 2 && !c[6] && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_mode == 2) begin
      end else if (dm) begin
        if (br) m_pend = 1;
      end else if (fe) begin
        m_pend = 0; m_mode = 0;
      end else if (m_mode == 1) begin
        if (m_left == 0) begin
          m_mode = 2; m_hlt = 1;
        end else m_left--;
      end else if (!hz && hl) begin
        m_mode = 1; m_left = DC - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_en, fd_en, fd_flush, dx_en, dx_bubble, xm_en, mwb_en};
      n_chk++;
      if (a !== e.ctl) begin
        n_err++;
        $display("FAIL ctl t=%0t got %b want %b", $time, a, e.ctl);
      end
      n_chk++;
      if (halted !== e.hlt) begin
        n_err++;
        $display("FAIL halted t=%0t got %b want %b", $time, halted, e.hlt);
      end
      n_chk++;
      if (stall_cycles !== CW'(e.cnt)) begin
        n_err++;
        $display("FAIL stall_cycles t=%0t got %0d want %0d",
                 $time, stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    int w;
    // reset, idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(5);
    // hazard x2, then hazard+flush
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(1);
    // freeze with flush in cycle 2
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    // halt from fresh reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, i[0], 1);
    // halt then flush in 2nd drain cycle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 1, 0, 0, 0);
    idle(5);
    // saturation
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0, 0, 0);
    // rst mid-drain
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
    // random
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 2,
          $urandom_range(99) < 25,
          $urandom_range(99) < 12,
          $urandom_range(99) < 20,
          $urandom_range(99) < 20,
          $urandom_range(99) < 8);
    end
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage core (F, D, X, M, WB).
- Merges four stall/flush sources into per-stage enable and squash controls for the PC and the FD/DX/XM/MWB pipeline registers:
  - the decode-stage hazard stall
  - the branch-resolution flush
  - the instruction-memory stall
  - the data-memory stall
- Also sequences HALT: fetch stops, the pipeline drains, and the controller parks in a halted state.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- DRAIN_CYCLES, 3: cycles spent draining X/M/WB after HALT leaves decode; legal range 1..7.
- CNT_W, 16: width of stall_cycles counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard_stall  input  1  RAW hazard in decode; D instruction must wait.
- branch_flush  input  1  branch/jump resolved taken in X; squash F and D.
- imem_stall  input  1  instruction memory not ready this cycle.
- dmem_stall  input  1  data memory busy; whole pipeline must freeze.
- halt_req  input  1  valid HALT instruction currently in decode.
- pc_en  output  1  PC register write enable.
- fd_en  output  1  FD register write enable.
- fd_flush  output  1  load NOP into FD, when fd_en=1.
- dx_en  output  1  DX register write enable.
- dx_bubble  output  1  load NOP into DX, when dx_en=1.
- xm_en  output  1  XM register write enable.
- mwb_en  output  1  MWB register write enable.
- halted  output  1  registered; core is halted.
- stall_cycles  output  CNT_W  registered saturating count of lost fetch cycles.

Behaviour:
- States: RUN, DRAIN, HALTED. Additional state:
  - 3-bit drain counter drn
  - 1-bit flush_pend
  - stall_cycles
- Reset (rst=1 at clk edge):
  - state=RUN, drn=0, flush_pend=0, stall_cycles=0, halted=0.
  - Outputs during rst cycle follow the RUN decode.
- Control outputs are combinational (Mealy) from state, flush_pend and inputs. halted and stall_cycles are registered.
- flush_eff = branch_flush | flush_pend.
- Freeze (any state except HALTED, dmem_stall=1):
  - all enables 0; fd_flush=0, dx_bubble=0.
  - state and drn hold.
  - If branch_flush=1, set flush_pend=1.
- RUN priority when dmem_stall=0, highest first:
  - flush_eff: all en=1, fd_flush=1, dx_bubble=1. hazard_stall, imem_stall and halt_req are ignored. Clear flush_pend.
  - hazard_stall: pc_en=0, fd_en=0, dx_en=1, dx_bubble=1, xm_en=mwb_en=1.
  - halt_req: pc_en=0, fd_en=1, fd_flush=1, dx_en=1 (HALT passes into DX), xm_en=mwb_en=1. Next state DRAIN, drn=DRAIN_CYCLES-1.
  - imem_stall: pc_en=0, fd_en=1, fd_flush=1, others en=1.
  - else: all en=1, no squash.
- DRAIN (dmem_stall=0):
  - pc_en=0, fd_en=1, fd_flush=1, dx_en=1, dx_bubble=1, xm_en=mwb_en=1.
  - If flush_eff: the HALT is younger than the branch and is squashed. Clear flush_pend, outputs as the RUN flush row, next state RUN.
  - Else if drn==0: next state HALTED, halted<=1.
  - Else drn<=drn-1.
- HALTED:
  - all enables 0, no squash.
  - All inputs ignored, including dmem_stall and branch_flush.
  - Exit only via rst.
- stall_cycles increments by 1 on every cycle with pc_en=0 and state!=HALTED. This includes freeze, hazard, imem, halt_req and DRAIN cycles.
  - Saturates at all-ones.
  - Reset to 0 by rst.
- Simultaneous events:
  - dmem_stall overrides everything.
  - flush beats hazard, halt and imem.
  - A flush arriving during freeze is held in flush_pend and applied on the first unfrozen cycle.

Test Plan:
- rst for 2 cycles, then all inputs 0 for 5 cycles -> all en=1, fd_flush=dx_bubble=0, halted=0, stall_cycles=0.
- hazard_stall=1 for 2 cycles -> pc_en=fd_en=0, dx_bubble=1 both cycles, xm_en=mwb_en=1; stall_cycles=2. Then hazard_stall=1 with branch_flush=1 in the same cycle -> fd_flush=1, dx_bubble=1, pc_en=1.
- dmem_stall=1 for 4 cycles with a branch_flush pulse in cycle 2 -> all en=0 for 4 cycles, no squash, stall_cycles +4. Cycle 5 (dmem_stall=0) -> fd_flush=1, dx_bubble=1, all en=1; cycle 6 normal.
- halt_req=1 for 1 cycle, DRAIN_CYCLES=3 -> fd_flush=1, pc_en=0 that cycle, then 3 DRAIN cycles with dx_bubble=1. halted=1 in the following cycle and stays; all en=0; stall_cycles frozen at 4.
- halt_req, then branch_flush during the 2nd DRAIN cycle -> that cycle fd_flush=dx_bubble=1, pc_en=1; state returns to RUN; halted never asserts.
- CNT_W=4, hazard_stall held 20 cycles -> stall_cycles reaches 15 and stays 15. rst mid-DRAIN -> next cycle RUN, halted=0, stall_cycles=0.
